// File: rtl/shared_bus_pkg.sv
// Shared bus scheduler package: FSM state type and default tenure limit.
package shared_bus_pkg;

  // Scheduler states; RELEASE is the mandatory one-cycle gap between tenures.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Default maximum consecutive grant cycles per tenure.
  localparam int unsigned MaxHoldDefault = 8;

endpackage

// File: rtl/shared_bus_rr_pick.sv
// Round-robin pick: lowest requesting index >= ptr, else lowest requesting index.
// Ports:
//   req    - per-requester request vector
//   ptr    - round-robin start index
//   onehot - one-hot selected requester (zero when nothing requested)
//   idx    - index of selected requester (0 when nothing requested)
//   any    - at least one request bit set
module rr_pick #(
  parameter int unsigned NumReq = 3
) (
  input  logic [NumReq-1:0]         req,
  input  logic [$clog2(NumReq)-1:0] ptr,
  output logic [NumReq-1:0]         onehot,
  output logic [$clog2(NumReq)-1:0] idx,
  output logic                      any
);

  localparam int unsigned IdxW = $clog2(NumReq);

  logic            hi_found;
  logic [IdxW-1:0] hi_idx;
  logic            lo_found;
  logic [IdxW-1:0] lo_idx;

  // Scan from the top down so the last hit is the lowest index in each class.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_found = 1'b1;
        lo_idx   = IdxW'(i);
        if (IdxW'(i) >= ptr) begin
          hi_found = 1'b1;
          hi_idx   = IdxW'(i);
        end
      end
    end
  end

  assign any    = lo_found;
  assign idx    = hi_found ? hi_idx : lo_idx;
  assign onehot = lo_found ? (NumReq'(1) << idx) : '0;

endmodule

// File: rtl/shared_bus_scheduler.sv
// Shared bus scheduler: round-robin tenure arbiter with a per-tenure hold limit.
// Ports:
//   clk           - clock, all state on rising edge
//   rstN          - asynchronous active-low reset
//   req           - per-requester level request, held until done
//   last          - per-requester final-cycle marker (only the granted bit matters)
//   grant         - registered one-hot grant or zero
//   grant_valid   - registered OR of grant
//   grant_idx     - registered index of the granted requester, 0 when idle
//   force_release - registered one-cycle pulse when a tenure hit the hold limit
module shared_bus_scheduler
  import shared_bus_pkg::*;
#(
  parameter int unsigned NumReq  = 3,
  parameter int unsigned MaxHold = MaxHoldDefault
) (
  input  logic                      clk,
  input  logic                      rstN,
  input  logic [NumReq-1:0]         req,
  input  logic [NumReq-1:0]         last,
  output logic [NumReq-1:0]         grant,
  output logic                      grant_valid,
  output logic [$clog2(NumReq)-1:0] grant_idx,
  output logic                      force_release
);

  localparam int unsigned IdxW  = $clog2(NumReq);
  localparam int unsigned HoldW = $clog2(MaxHold + 1);

  state_t            state;
  logic [IdxW-1:0]   ptr;
  logic [HoldW-1:0]  hold_cnt;

  logic [NumReq-1:0] pick_onehot;
  logic [IdxW-1:0]   pick_idx;
  logic              pick_any;

  logic              cur_req;
  logic              cur_last;
  logic              done_norm;
  logic              hold_max;
  logic              tenure_end;
  logic [IdxW-1:0]   ptr_next;

  rr_pick #(
    .NumReq(NumReq)
  ) u_rr_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Exit decode on the granted index only; other requesters' req/last are ignored.
  assign cur_req    = req[grant_idx];
  assign cur_last   = last[grant_idx];
  assign done_norm  = !cur_req || cur_last;
  assign hold_max   = (hold_cnt == HoldW'(MaxHold - 1));
  assign tenure_end = done_norm || hold_max;
  assign ptr_next   = (grant_idx == IdxW'(NumReq - 1)) ? '0 : grant_idx + IdxW'(1);

  // Scheduler FSM with registered outputs.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state         <= IDLE;
      ptr           <= '0;
      hold_cnt      <= '0;
      grant         <= '0;
      grant_valid   <= 1'b0;
      grant_idx     <= '0;
      force_release <= 1'b0;
    end else begin
      force_release <= 1'b0;
      case (state)
        IDLE, RELEASE: begin
          if (pick_any) begin
            state       <= GRANT;
            grant       <= pick_onehot;
            grant_valid <= 1'b1;
            grant_idx   <= pick_idx;
            hold_cnt    <= '0;
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          if (tenure_end) begin
            state         <= RELEASE;
            grant         <= '0;
            grant_valid   <= 1'b0;
            grant_idx     <= '0;
            ptr           <= ptr_next;
            // Pulse only when the hold limit alone ended the tenure.
            force_release <= !done_norm;
          end else if (!hold_max) begin
            hold_cnt <= hold_cnt + HoldW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_bus_scheduler.sv
// Bench for shared_bus_scheduler (NumReq=3, MaxHold=4): directed scenarios with
// literal expectations plus randomized traffic against a tenure-level model.
module tb_shared_bus_scheduler;

  localparam int unsigned N = 3;
  localparam int unsigned M = 4;

  logic         clk  = 1'b0;
  logic         rstN = 1'b1;
  logic [N-1:0] req  = '0;
  logic [N-1:0] last = '0;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [1:0]   grant_idx;
  logic         force_release;

  int vectors     = 0;
  int miscompares = 0;

  // Model: who owns the bus, how many cycles it has had, where the next search starts.
  int m_owner = -1;
  int m_len   = 0;
  int m_ptr   = 0;
  bit m_fr    = 1'b0;
  int mk;
  int mused;
  int mc;

  always #5 clk = ~clk;

  shared_bus_scheduler #(
    .NumReq  (N),
    .MaxHold (M)
  ) dut (
    .clk           (clk),
    .rstN          (rstN),
    .req           (req),
    .last          (last),
    .grant         (grant),
    .grant_valid   (grant_valid),
    .grant_idx     (grant_idx),
    .force_release (force_release)
  );

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // A tenure ends when the owner drops req, marks last, or has used M cycles;
  // the cycle after an end is always grant-free, then the search resumes.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      m_owner = -1;
      m_len   = 0;
      m_ptr   = 0;
      m_fr    = 1'b0;
    end else if (m_owner >= 0) begin
      mk    = m_owner;
      mused = m_len + 1;
      if (!req[mk] || last[mk] || mused == int'(M)) begin
        m_fr    = (mused == int'(M)) && req[mk] && !last[mk];
        m_owner = -1;
        m_ptr   = (mk + 1) % int'(N);
      end else begin
        m_len = mused;
        m_fr  = 1'b0;
      end
    end else begin
      m_fr = 1'b0;
      for (int j = 0; j < int'(N); j++) begin
        mc = (m_ptr + j) % int'(N);
        if (req[mc] && m_owner < 0) begin
          m_owner = mc;
          m_len   = 0;
        end
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    chk("cyc.grant", int'(grant), (m_owner >= 0) ? (1 << m_owner) : 0);
    chk("cyc.grant_valid", int'(grant_valid), (m_owner >= 0) ? 1 : 0);
    chk("cyc.grant_idx", int'(grant_idx), (m_owner >= 0) ? m_owner : 0);
    chk("cyc.force_release", int'(force_release), int'(m_fr));
  end

  task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] l);
    @(negedge clk);
    #2;
    req  = r;
    last = l;
  endtask

  task automatic lit(input string nm, input logic [N-1:0] g, input bit fr);
    @(posedge clk);
    #1;
    chk({nm, ".grant"}, int'(grant), int'(g));
    chk({nm, ".force_release"}, int'(force_release), int'(fr));
  endtask

  task automatic lit_idle(input string nm);
    chk({nm, ".grant"}, int'(grant), 0);
    chk({nm, ".grant_valid"}, int'(grant_valid), 0);
    chk({nm, ".grant_idx"}, int'(grant_idx), 0);
    chk({nm, ".force_release"}, int'(force_release), 0);
  endtask

  logic [N-1:0] seq033 [7] = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};

  initial begin
    // Reset for two cycles, then first grant one cycle after release.
    #1 rstN = 1'b0;
    #1 lit_idle("rst_async");
    repeat (2) @(posedge clk);
    #1 lit_idle("rst_hold");
    @(negedge clk);
    #2;
    rstN = 1'b1;
    req  = 3'b001;
    last = 3'b000;
    lit("first_grant", 3'b001, 1'b0);

    // Sole requester without last: 4-cycle tenure, forced release, regrant.
    repeat (3) begin
      cyc(3'b001, 3'b000);
      lit("hold", 3'b001, 1'b0);
    end
    cyc(3'b001, 3'b000);
    lit("hold_limit", 3'b000, 1'b1);
    cyc(3'b001, 3'b000);
    lit("self_regrant", 3'b001, 1'b0);
    cyc(3'b000, 3'b000);
    lit("drop0", 3'b000, 1'b0);
    cyc(3'b000, 3'b000);
    lit("idle0", 3'b000, 1'b0);

    // Requester 1 with last on its second grant cycle; next search starts at 2.
    cyc(3'b010, 3'b000);
    lit("r1_c1", 3'b010, 1'b0);
    cyc(3'b010, 3'b000);
    lit("r1_c2", 3'b010, 1'b0);
    cyc(3'b010, 3'b010);
    lit("r1_end", 3'b000, 1'b0);
    cyc(3'b111, 3'b000);
    lit("ptr2_pick", 3'b100, 1'b0);
    cyc(3'b111, 3'b111);
    lit("r2_end", 3'b000, 1'b0);

    // All requesting with last every cycle: rotation with one-cycle gaps.
    for (int i = 0; i < 7; i++) begin
      cyc(3'b111, 3'b111);
      lit($sformatf("rotate%0d", i), seq033[i], 1'b0);
    end
    cyc(3'b000, 3'b000);
    lit("rot_drop", 3'b000, 1'b0);
    cyc(3'b000, 3'b000);
    lit("rot_idle", 3'b000, 1'b0);

    // Requester 2 drops req mid-tenure: no forced release, search from 0.
    cyc(3'b100, 3'b000);
    lit("r2_c1", 3'b100, 1'b0);
    cyc(3'b100, 3'b000);
    lit("r2_c2", 3'b100, 1'b0);
    cyc(3'b000, 3'b000);
    lit("r2_drop", 3'b000, 1'b0);
    cyc(3'b011, 3'b000);
    lit("ptr0_pick", 3'b001, 1'b0);
    cyc(3'b010, 3'b000);
    lit("r0_drop", 3'b000, 1'b0);
    cyc(3'b010, 3'b000);
    lit("r1_grant", 3'b010, 1'b0);

    // Asynchronous reset mid-tenure of requester 1.
    @(negedge clk);
    #3 rstN = 1'b0;
    #1 lit_idle("mid_rst");
    @(posedge clk);
    #1 lit_idle("mid_rst_edge");
    @(negedge clk);
    #2;
    rstN = 1'b1;
    req  = 3'b011;
    last = 3'b000;
    lit("ptr_after_rst", 3'b001, 1'b0);
    cyc(3'b000, 3'b000);
    lit("post_rst_drop", 3'b000, 1'b0);

    // Randomized traffic with occasional asynchronous resets.
    repeat (2000) begin
      @(negedge clk);
      #2;
      rstN = ($urandom_range(0, 199) != 0);
      for (int i = 0; i < int'(N); i++) begin
        req[i]  = ($urandom_range(0, 9) < 7);
        last[i] = ($urandom_range(0, 9) < 2);
      end
    end
    @(negedge clk);
    #2 rstN = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
